// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_muldiv
//  Description : Multi-cycle integer ALU. Single-cycle add/sub/logic/compare
//                plus iterative shift-add multiply and restoring divide,
//                behind one valid/ready handshake. Produces ARM NZCV flags
//                and a RISC-V style zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_and   = 4'b0010;
    localparam logic [3:0] c_op_or    = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_slt   = 4'b0101;
    localparam logic [3:0] c_op_sltu  = 4'b0110;
    localparam logic [3:0] c_op_mul   = 4'b1000;
    localparam logic [3:0] c_op_mulhu = 4'b1001;
    localparam logic [3:0] c_op_divu  = 4'b1010;
    localparam logic [3:0] c_op_remu  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_flags;

    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_bx;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_single_res;
    logic [3:0]           w_single_flags;
    logic                 w_c;
    logic                 w_v;
    logic                 w_known_op;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_iter_res;

    assign w_is_mul   = (op == c_op_mul) || (op == c_op_mulhu);
    assign w_is_div   = (op == c_op_divu) || (op == c_op_remu);
    assign w_div_zero = (b == '0);

    // Single-cycle datapath on the incoming operands; one shared adder for ADD/SUB
    always_comb begin
        w_bx         = (op == c_op_sub) ? ~b : b;
        w_sum        = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, (op == c_op_sub)};
        w_single_res = '0;
        w_c          = 1'b0;
        w_v          = 1'b0;
        w_known_op   = 1'b1;
        case (op)
            c_op_add, c_op_sub: begin
                w_single_res = w_sum[WIDTH-1:0];
                w_c          = w_sum[WIDTH];
                w_v          = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_and:   w_single_res = a & b;
            c_op_or:    w_single_res = a | b;
            c_op_xor:   w_single_res = a ^ b;
            c_op_slt:   w_single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu:  w_single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // Only reach DONE directly on a zero divisor
            c_op_divu:  w_single_res = '1;
            c_op_remu:  w_single_res = a;
            c_op_mul, c_op_mulhu: w_single_res = '0;
            default:    w_known_op = 1'b0;
        endcase
        w_single_flags = w_known_op ?
                         {w_single_res[WIDTH-1], (w_single_res == '0), w_c, w_v} : 4'b0000;
    end

    // One shift-add / restoring-divide step on the registered state
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        // A set top bit means the trial subtraction borrowed: restore
        w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
        w_iter_res  = '0;
        if (r_state == S_MUL)
            w_iter_res = (r_op == c_op_mulhu) ? w_mul_next[2*WIDTH-1:WIDTH] : w_mul_next[WIDTH-1:0];
        else if (r_state == S_DIV)
            w_iter_res = (r_op == c_op_remu) ? w_div_next[2*WIDTH-1:WIDTH] : w_div_next[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_is_mul)                    w_next = S_MUL;
                    else if (w_is_div && !w_div_zero) w_next = S_DIV;
                    else                             w_next = S_DONE;
                end
            end
            S_MUL, S_DIV: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration state and result/flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op     <= op;
                    r_a      <= a;
                    r_b      <= b;
                    r_cnt    <= CNT_W'(WIDTH - 1);
                    r_acc    <= w_is_mul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                    r_result <= w_single_res;
                    r_flags  <= w_single_flags;
                end
                S_MUL, S_DIV: begin
                    r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result <= w_iter_res;
                        r_flags  <= {w_iter_res[WIDTH-1], (w_iter_res == '0), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;
    assign zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_muldiv
//  Description : Scoreboard bench for alu_seq_muldiv with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        zero;

    alu_seq_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic        z;
        int          acc;   // cycle in which the request was presented
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Present one request once the unit is ready and push its expected response
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [3:0] ef, input int lat);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout");
            return;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        e.res = er; e.flg = ef; e.z = (er == 32'h0); e.acc = cyc; e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) fail("drain_timeout");
    endtask

    // Monitor: compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && cyc > q[0].acc) chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_out_valid");
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                    end
                    chk("result", {32'd0, result}, {32'd0, q[0].res});
                    chk("flags",  {60'd0, flags},  {60'd0, q[0].flg});
                    chk("zero",   {63'd0, zero},   {63'd0, q[0].z});
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'h0; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result",    {32'd0, result},    64'd0);
        chk("rst_flags",     {60'd0, flags},     64'd0);
        chk("rst_zero",      {63'd0, zero},      64'd1);
        reset = 1'b0;

        //        op       a             b             result        NZCV     lat
        issue(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1);
        issue(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1);
        issue(4'b0001, 32'd5,        32'd5,        32'h00000000, 4'b0110, 1);
        issue(4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1000, 1);
        issue(4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1);
        issue(4'b0011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000, 1);
        issue(4'b0100, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0100, 1);
        issue(4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
        issue(4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1);
        issue(4'b0111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000, 1);
        issue(4'b1000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b1000, 33);
        issue(4'b1001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0000, 33);
        issue(4'b1010, 32'd100,      32'd7,        32'd14,       4'b0000, 33);
        issue(4'b1011, 32'd100,      32'd7,        32'd2,        4'b0000, 33);
        issue(4'b1010, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b1000, 1);
        issue(4'b1011, 32'd9,        32'd0,        32'd9,        4'b0000, 1);
        drain();

        // Backpressure: result held for 5 cycles while a new request is offered
        out_ready = 1'b0;
        issue(4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
        repeat (5) begin
            @(negedge clk);
            op = 4'b0000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a divide aborts it
        issue(4'b1010, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_in_ready",  {63'd0, in_ready},  64'd1);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result",    {32'd0, result},    64'd0);
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_result", {63'd0, out_valid}, 64'd0);

        issue(4'b0000, 32'd1, 32'd1, 32'd2, 4'b0000, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
